// File: rtl/pkg_juego.sv
// Shared constants for the car-dodging game: palette, default sprite size and active-video geometry.
package pkg_juego;

    localparam logic [2:0] COLOR_FONDO   = 3'd0;
    localparam logic [2:0] COLOR_CARRO   = 3'd1;
    localparam logic [2:0] COLOR_BORDE   = 3'd3;
    localparam logic [2:0] COLOR_JUGADOR = 3'd7;

    localparam int ANCHO_CARRO_DEF = 85;
    localparam int ALTO_CARRO_DEF  = 90;
    localparam int V_ACTIVO        = 480;
    localparam int H_ACTIVO        = 640;

    typedef enum logic [1:0] {
        CAPA_FONDO,
        CAPA_BORDE,
        CAPA_CARRO,
        CAPA_JUGADOR
    } capa_t;

    // Maps the winning layer of a pixel onto its palette entry.
    function automatic logic [2:0] colorDeCapa(input capa_t capa);
        case (capa)
            CAPA_JUGADOR: return COLOR_JUGADOR;
            CAPA_CARRO:   return COLOR_CARRO;
            CAPA_BORDE:   return COLOR_BORDE;
            default:      return COLOR_FONDO;
        endcase
    endfunction

endpackage

// File: rtl/detector_rectangulo.sv
// Combinational sprite box test: inclusive start, exclusive end, optional vertical wrap past MODULO.
module detector_rectangulo
    import pkg_juego::*;
#(
    parameter int ANCHO    = ANCHO_CARRO_DEF,
    parameter int ALTO     = ALTO_CARRO_DEF,
    parameter int MODULO   = V_ACTIVO,
    parameter bit ENVOLVER = 1'b0
) (
    input  logic [10:0] pixelX,
    input  logic [9:0]  pixelY,
    input  logic [9:0]  origenX,
    input  logic [9:0]  origenY,
    output logic        hit
);

    logic [11:0] finX;
    logic [10:0] finY;
    logic        dentroX;
    logic        dentroY;
    logic        dentroEnvuelto;

    // A sprite crossing the bottom edge reappears as a slice at the top of the screen.
    always_comb begin
        finX = {2'b00, origenX} + 12'(ANCHO);
        finY = {1'b0, origenY} + 11'(ALTO);
        dentroX = ({1'b0, pixelX} >= {2'b00, origenX}) && ({1'b0, pixelX} < finX);
        dentroY = (pixelY >= origenY) && ({1'b0, pixelY} < finY);
        dentroEnvuelto = 1'b0;
        if (ENVOLVER && (finY > 11'(MODULO)))
            dentroEnvuelto = {1'b0, pixelY} < (finY - 11'(MODULO));
        hit = dentroX && (dentroY || dentroEnvuelto);
    end

endmodule

// File: rtl/compositor_carros.sv
// Two-stage pixel compositor: borders, obstacle cars and player car layered into 3-bit RGB.
// Define COMPOSITOR_COLISION_EN to build the per-frame collision accumulator and its outputs.
module compositor_carros #(
    parameter int NUM_CARROS  = 3,
    parameter int ANCHO_CARRO = pkg_juego::ANCHO_CARRO_DEF,
    parameter int ALTO_CARRO  = pkg_juego::ALTO_CARRO_DEF,
    parameter int Y_JUGADOR   = 360,
    parameter int BORDE_IZQ   = 215,
    parameter int BORDE_DER   = 425,
    parameter int V_ACTIVO    = pkg_juego::V_ACTIVO
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [10:0]             iPixelX,
    input  logic [9:0]              iPixelY,
    input  logic                    iPixelValido,
    input  logic                    iInicioCuadro,
    input  logic                    iPintarCarros,
    input  logic                    iPintarJugador,
    input  logic [10*NUM_CARROS-1:0] iPosicionX,
    input  logic [9*NUM_CARROS-1:0]  iPosicionY,
    input  logic [9:0]              iPosicionJugador,
    output logic [2:0]              oColorRGB,
    output logic                    oPixelValido,
    output logic                    oColision,
    output logic [NUM_CARROS-1:0]   oColisionCarro
);

    import pkg_juego::*;

    logic [NUM_CARROS-1:0] hitCarro;
    logic                  hitJugador;
    logic                  hitBorde;

    logic [NUM_CARROS-1:0] hitCarroQ;
    logic                  hitJugadorQ;
    logic                  hitBordeQ;
    logic                  validoQ;
    logic                  pintarCarrosQ;
    logic                  pintarJugadorQ;

    capa_t                 capa;
    logic [2:0]            colorSig;

    for (genvar i = 0; i < NUM_CARROS; i++) begin : genCarros
        detector_rectangulo #(
            .ANCHO    (ANCHO_CARRO),
            .ALTO     (ALTO_CARRO),
            .MODULO   (V_ACTIVO),
            .ENVOLVER (1'b1)
        ) uDetector (
            .pixelX  (iPixelX),
            .pixelY  (iPixelY),
            .origenX (iPosicionX[10*i +: 10]),
            .origenY ({1'b0, iPosicionY[9*i +: 9]}),
            .hit     (hitCarro[i])
        );
    end

    detector_rectangulo #(
        .ANCHO    (ANCHO_CARRO),
        .ALTO     (ALTO_CARRO),
        .MODULO   (V_ACTIVO),
        .ENVOLVER (1'b0)
    ) uDetectorJugador (
        .pixelX  (iPixelX),
        .pixelY  (iPixelY),
        .origenX (iPosicionJugador),
        .origenY (10'(Y_JUGADOR)),
        .hit     (hitJugador)
    );

    assign hitBorde = (iPixelX < 11'(BORDE_IZQ)) || (iPixelX >= 11'(BORDE_DER));

    // Stage 1 captures raw hits with the enables and valid flag that travel alongside them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hitCarroQ      <= '0;
            hitJugadorQ    <= 1'b0;
            hitBordeQ      <= 1'b0;
            validoQ        <= 1'b0;
            pintarCarrosQ  <= 1'b0;
            pintarJugadorQ <= 1'b0;
        end else begin
            hitCarroQ      <= hitCarro;
            hitJugadorQ    <= hitJugador;
            hitBordeQ      <= hitBorde;
            validoQ        <= iPixelValido;
            pintarCarrosQ  <= iPintarCarros;
            pintarJugadorQ <= iPintarJugador;
        end
    end

    always_comb begin
        capa = CAPA_FONDO;
        if (pintarJugadorQ && hitJugadorQ)
            capa = CAPA_JUGADOR;
        else if (pintarCarrosQ && (|hitCarroQ))
            capa = CAPA_CARRO;
        else if (pintarCarrosQ && hitBordeQ)
            capa = CAPA_BORDE;
        colorSig = validoQ ? colorDeCapa(capa) : COLOR_FONDO;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oColorRGB    <= COLOR_FONDO;
            oPixelValido <= 1'b0;
        end else begin
            oColorRGB    <= colorSig;
            oPixelValido <= validoQ;
        end
    end

`ifdef COMPOSITOR_COLISION_EN
    logic [NUM_CARROS-1:0] acumulador;
    logic [NUM_CARROS-1:0] colisionPixel;

    assign colisionPixel = (validoQ && hitJugadorQ && pintarCarrosQ && pintarJugadorQ)
                           ? hitCarroQ : '0;

    // At frame start the old frame is reported while the pixel now leaving stage 2 seeds the new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acumulador     <= '0;
            oColisionCarro <= '0;
            oColision      <= 1'b0;
        end else if (iInicioCuadro) begin
            acumulador     <= colisionPixel;
            oColisionCarro <= acumulador;
            oColision      <= |acumulador;
        end else begin
            acumulador     <= acumulador | colisionPixel;
        end
    end
`else
    logic unusedInicioCuadro;

    assign unusedInicioCuadro = iInicioCuadro;
    assign oColision          = 1'b0;
    assign oColisionCarro     = '0;
`endif

endmodule

// File: tb/tb_compositor_carros.sv
// Self-checking bench for compositor_carros against a coordinate-level model of the layering rules.
module tb_compositor_carros;

    localparam int N     = 3;
    localparam int ANCHO = 85;
    localparam int ALTO  = 90;
    localparam int YJ    = 360;
    localparam int BIZQ  = 215;
    localparam int BDER  = 425;
    localparam int VACT  = 480;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   iPixelX;
    logic [9:0]    iPixelY;
    logic          iPixelValido;
    logic          iInicioCuadro;
    logic          iPintarCarros;
    logic          iPintarJugador;
    logic [10*N-1:0] iPosicionX;
    logic [9*N-1:0]  iPosicionY;
    logic [9:0]    iPosicionJugador;
    logic [2:0]    oColorRGB;
    logic          oPixelValido;
    logic          oColision;
    logic [N-1:0]  oColisionCarro;

    compositor_carros #(
        .NUM_CARROS  (N),
        .ANCHO_CARRO (ANCHO),
        .ALTO_CARRO  (ALTO),
        .Y_JUGADOR   (YJ),
        .BORDE_IZQ   (BIZQ),
        .BORDE_DER   (BDER),
        .V_ACTIVO    (VACT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .iPixelX          (iPixelX),
        .iPixelY          (iPixelY),
        .iPixelValido     (iPixelValido),
        .iInicioCuadro    (iInicioCuadro),
        .iPintarCarros    (iPintarCarros),
        .iPintarJugador   (iPintarJugador),
        .iPosicionX       (iPosicionX),
        .iPosicionY       (iPosicionY),
        .iPosicionJugador (iPosicionJugador),
        .oColorRGB        (oColorRGB),
        .oPixelValido     (oPixelValido),
        .oColision        (oColision),
        .oColisionCarro   (oColisionCarro)
    );

    always #5 clk = ~clk;

    typedef struct {
        int color;
        int valido;
        int bits;
    } esperado_t;

    int        checks = 0;
    int        errors = 0;
    int        carX[N];
    int        carY[N];
    int        jugX;
    esperado_t pipe[$];
    int        acc;
    int        reportado;
    int        lastPulse;

    function automatic bit dentro(int p, int lo, int size);
        return (p >= lo) && (p < lo + size);
    endfunction

    // Expected outcome of one pixel, straight from the layering and hit rules.
    function automatic esperado_t modelo(int px, int py, int v, int pc, int pj);
        esperado_t e;
        bit        jug;
        bit        borde;
        int        hits;
        hits = 0;
        for (int i = 0; i < N; i++) begin
            if (dentro(px, carX[i], ANCHO) &&
                (dentro(py, carY[i], ALTO) ||
                 ((carY[i] + ALTO > VACT) && (py < carY[i] + ALTO - VACT))))
                hits |= (1 << i);
        end
        jug   = dentro(px, jugX, ANCHO) && dentro(py, YJ, ALTO);
        borde = (px < BIZQ) || (px >= BDER);
        e.color = 0;
        if (v != 0) begin
            if (pj != 0 && jug)             e.color = 7;
            else if (pc != 0 && hits != 0)  e.color = 1;
            else if (pc != 0 && borde)      e.color = 3;
        end
        e.valido = v;
        e.bits   = (v != 0 && jug && pc != 0 && pj != 0) ? hits : 0;
        return e;
    endfunction

    // One pixel clock: check what left stage 2 at the last edge, then drive the next pixel.
    task automatic step(string nombre, int px, int py, int v, int pc, int pj, int pulse);
        esperado_t e;
        @(negedge clk);
        e = pipe.pop_front();
`ifdef COMPOSITOR_COLISION_EN
        if (lastPulse != 0) begin
            reportado = acc;
            acc       = e.bits;
        end else begin
            acc |= e.bits;
        end
`endif
        checks++;
        if (oColorRGB !== 3'(e.color)) begin
            errors++;
            $display("[TB] FAIL %s color: got %0d expected %0d", nombre, oColorRGB, e.color);
        end
        checks++;
        if (oPixelValido !== 1'(e.valido)) begin
            errors++;
            $display("[TB] FAIL %s valido: got %0d expected %0d", nombre, oPixelValido, e.valido);
        end
        checks++;
        if (oColisionCarro !== 3'(reportado)) begin
            errors++;
            $display("[TB] FAIL %s colisionCarro: got %b expected %b", nombre, oColisionCarro, 3'(reportado));
        end
        checks++;
        if (oColision !== (reportado != 0)) begin
            errors++;
            $display("[TB] FAIL %s colision: got %0d expected %0d", nombre, oColision, reportado != 0);
        end
        iPixelX        = 11'(px);
        iPixelY        = 10'(py);
        iPixelValido   = 1'(v);
        iPintarCarros  = 1'(pc);
        iPintarJugador = 1'(pj);
        iInicioCuadro  = 1'(pulse);
        for (int i = 0; i < N; i++) begin
            iPosicionX[10*i +: 10] = 10'(carX[i]);
            iPosicionY[9*i +: 9]   = 9'(carY[i]);
        end
        iPosicionJugador = 10'(jugX);
        pipe.push_back(modelo(px, py, v, pc, pj));
        lastPulse = pulse;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step("idle", 0, 0, 0, 1, 1, 0);
    endtask

    // Asynchronous reset: outputs must drop at once, without waiting for a clock edge.
    task automatic doReset(string nombre);
        esperado_t cero;
        #2;
        iPixelValido  = 1'b0;
        iInicioCuadro = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (oColorRGB !== 3'd0 || oPixelValido !== 1'b0 || oColision !== 1'b0 || oColisionCarro !== 3'd0) begin
            errors++;
            $display("[TB] FAIL %s reset outputs: got rgb=%0d val=%0d col=%0d carros=%b expected all 0",
                     nombre, oColorRGB, oPixelValido, oColision, oColisionCarro);
        end
        @(negedge clk);
        reset = 1'b0;
        cero.color = 0;
        cero.valido = 0;
        cero.bits = 0;
        pipe.delete();
        pipe.push_back(cero);
        pipe.push_back(cero);
        acc = 0;
        reportado = 0;
        lastPulse = 0;
    endtask

    task automatic test_reset();
        iPixelX = '0; iPixelY = '0; iPixelValido = 1'b0; iInicioCuadro = 1'b0;
        iPintarCarros = 1'b0; iPintarJugador = 1'b0;
        iPosicionX = '0; iPosicionY = '0; iPosicionJugador = '0;
        carX = '{600, 600, 600};
        carY = '{0, 150, 300};
        jugX = 600;
        doReset("reset");
        idle(3);
    endtask

    task automatic test_basic();
        carX = '{300, 600, 600};
        carY = '{100, 150, 300};
        step("car0_inside", 300, 100, 1, 1, 0, 0);
        step("car0_right_edge", 385, 100, 1, 1, 0, 0);
        step("border", 100, 50, 1, 1, 0, 0);
        step("car0_last_col", 384, 189, 1, 1, 0, 0);
        step("car0_below", 300, 190, 1, 1, 0, 0);
        step("border_right", 425, 10, 1, 1, 0, 0);
        idle(2);
    endtask

    task automatic test_wrap();
        carX = '{600, 250, 600};
        carY = '{100, 450, 300};
        step("wrap_450", 260, 450, 1, 1, 0, 0);
        step("wrap_479", 260, 479, 1, 1, 0, 0);
        step("wrap_0", 260, 0, 1, 1, 0, 0);
        step("wrap_59", 260, 59, 1, 1, 0, 0);
        step("wrap_60", 260, 60, 1, 1, 0, 0);
        step("wrap_449", 260, 449, 1, 1, 0, 0);
        idle(2);
    endtask

    task automatic test_collision();
        carX = '{300, 600, 600};
        carY = '{350, 0, 200};
        jugX = 300;
        step("clear_frame", 0, 0, 0, 1, 1, 1);
        step("overlap", 310, 370, 1, 1, 1, 0);
        idle(2);
        step("frame_a", 0, 0, 0, 1, 1, 1);
        step("after_frame_a", 0, 0, 0, 1, 1, 0);
`ifdef COMPOSITOR_COLISION_EN
        checks++;
        if (oColision !== 1'b1 || oColisionCarro !== 3'b001) begin
            errors++;
            $display("[TB] FAIL collision_report: got col=%0d carros=%b expected 1 001", oColision, oColisionCarro);
        end
`endif
        step("no_overlap", 100, 100, 1, 1, 1, 0);
        idle(2);
        step("frame_b", 0, 0, 0, 1, 1, 1);
        idle(2);
    endtask

    task automatic test_mask();
        step("mask_overlap", 310, 370, 1, 0, 1, 0);
        step("mask_car_only", 310, 352, 1, 0, 1, 0);
        step("mask_border", 50, 50, 1, 0, 0, 0);
        idle(2);
        step("mask_frame", 0, 0, 0, 1, 1, 1);
        idle(2);
    endtask

    task automatic test_invalid();
        step("invalid_player", 310, 400, 0, 1, 1, 0);
        step("valid_player", 310, 400, 1, 1, 1, 0);
        idle(2);
    endtask

    task automatic test_frame_boundary();
        step("fb_clear", 0, 0, 0, 1, 1, 1);
        step("fb_clear2", 0, 0, 0, 1, 1, 1);
        step("fb_hit", 310, 370, 1, 1, 1, 0);
        step("fb_pulse", 0, 0, 0, 1, 1, 1);
        idle(2);
        step("fb_pulse2", 0, 0, 0, 1, 1, 1);
        idle(2);
    endtask

    task automatic test_random();
        int k;
        int px;
        int py;
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) begin
                for (int i = 0; i < N; i++) begin
                    carX[i] = $urandom_range(639, 0);
                    carY[i] = $urandom_range(479, 0);
                end
                jugX = $urandom_range(639, 0);
            end
            k = $urandom_range(N, 0);
            if (k == N) begin
                px = (jugX + $urandom_range(ANCHO + 10, 0) - 5 < 0) ? 0 : jugX + $urandom_range(ANCHO + 10, 0) - 5;
                py = YJ + $urandom_range(ALTO + 10, 0) - 5;
            end else begin
                px = carX[k] + $urandom_range(ANCHO + 10, 0);
                px = (px < 5) ? 0 : px - 5;
                py = (carY[k] + $urandom_range(ALTO + 10, 0)) % VACT;
            end
            step("random", px, py, ($urandom_range(9, 0) != 0) ? 1 : 0,
                 ($urandom_range(5, 0) != 0) ? 1 : 0, ($urandom_range(5, 0) != 0) ? 1 : 0,
                 ($urandom_range(9, 0) == 0) ? 1 : 0);
        end
        idle(3);
    endtask

    task automatic test_reset_midframe();
        carX = '{300, 600, 600};
        carY = '{350, 0, 200};
        jugX = 300;
        step("rm_hit", 310, 370, 1, 1, 1, 0);
        step("rm_pulse", 0, 0, 0, 1, 1, 1);
        step("rm_hit2", 320, 380, 1, 1, 1, 0);
        step("rm_hit3", 330, 390, 1, 1, 1, 0);
        doReset("reset_midframe");
        step("rm_after", 0, 0, 0, 1, 1, 0);
        step("rm_pulse_after", 0, 0, 0, 1, 1, 1);
        idle(3);
    endtask

    initial begin
        reset = 1'b1;
        acc = 0;
        reportado = 0;
        lastPulse = 0;
        $display("[TB] compositor_carros bench start");
        test_reset();
        test_basic();
        test_wrap();
        test_collision();
        test_mask();
        test_invalid();
        test_frame_boundary();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
